// File: rtl/draw_sprite_pkg.sv
// Shared game constants and the side-band bundle that rides alongside the
// sprite ROM fetch in the draw chain.
package draw_sprite_pkg;

  localparam int          TOM_W      = 32;
  localparam int          TOM_H      = 48;
  localparam int          TOM_FRAMES = 4;
  localparam logic [11:0] TOM_BG     = 12'h0F0;

  typedef struct packed {
    logic [9:0]  vcount;
    logic        vsync;
    logic        vblnk;
    logic [9:0]  hcount;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;
  } vga_t;

  typedef struct packed {
    logic inbox;
    vga_t vga;
  } side_t;

  // Counter width that stays >= 1 when only a single value is needed.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pos_if.sv
// Sprite position as seen by the host/game logic.
interface pos_if;
  logic [9:0] x;
  logic [9:0] y;

  modport in  (input  x, y);
  modport out (output x, y);
endinterface

// File: rtl/vga_if.sv
// VGA timing + colour bundle passed between draw stages.
interface vga_if;
  logic [9:0]  vcount;
  logic        vsync;
  logic        vblnk;
  logic [9:0]  hcount;
  logic        hsync;
  logic        hblnk;
  logic [11:0] rgb;

  modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
  modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/delay.sv
// Fixed-depth register delay line with async active-low clear.
module delay #(
  parameter int CLK_DEL = 3,
  parameter int WIDTH   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [CLK_DEL-1:0][WIDTH-1:0] pipe_q, pipe_d;

  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = din;
    for (int i = 1; i < CLK_DEL; i++) pipe_d[i] = pipe_q[i-1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pipe_q <= '0;
    else      pipe_q <= pipe_d;
  end

  assign dout = pipe_q[CLK_DEL-1];

endmodule

// File: rtl/sprite_anim_ctrl.sv
// Vblank edge detect and animation sequencer; frame_idx only moves on a
// vblank rising edge so a displayed frame is never torn.
module sprite_anim_ctrl
  import draw_sprite_pkg::*;
#(
  parameter int FRAMES    = 4,
  parameter int FRAME_DIV = 8,
  parameter int FI_W      = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            vblnk,
  input  logic            anim_en,
  output logic            vblnk_rise,
  output logic [FI_W-1:0] frame_idx
);

  localparam int DIV_W = clog2_min1(FRAME_DIV);

  typedef enum logic [1:0] {STATIC, RUN, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [FI_W-1:0]   frame_q, frame_d;
  logic              vblnk_prev_q;
  logic              wrap;

  assign vblnk_rise = vblnk & ~vblnk_prev_q;
  assign frame_idx  = frame_q;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    frame_d = frame_q;
    wrap    = 1'b0;
    if (vblnk_rise) begin
      unique case (state_q)
        STATIC: begin
          div_d   = '0;
          frame_d = '0;
          if (FRAMES > 1 && anim_en) state_d = RUN;
        end
        RUN, DRAIN: begin
          if (div_q == DIV_W'(FRAME_DIV - 1)) begin
            div_d   = '0;
            wrap    = (frame_q == FI_W'(FRAMES - 1));
            frame_d = wrap ? '0 : frame_q + 1'b1;
          end else begin
            div_d = div_q + 1'b1;
          end
          // Draining stops only once the cycle is back on frame 0.
          if (anim_en)   state_d = RUN;
          else if (wrap) state_d = STATIC;
          else           state_d = DRAIN;
        end
        default: state_d = STATIC;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= STATIC;
      div_q        <= '0;
      frame_q      <= '0;
      vblnk_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      frame_q      <= frame_d;
      vblnk_prev_q <= vblnk;
    end
  end

endmodule

// File: rtl/draw_sprite.sv
// Overlays one animated, optionally mirrored ROM sprite onto the VGA stream;
// output timing is the input delayed by ROM_LAT+3 cycles.
module draw_sprite
  import draw_sprite_pkg::*;
#(
  parameter int          SPR_W     = TOM_W,
  parameter int          SPR_H     = TOM_H,
  parameter int          FRAMES    = TOM_FRAMES,
  parameter int          FRAME_DIV = 8,
  parameter int          ROM_LAT   = 1,
  parameter logic [11:0] BG_COLOR  = TOM_BG,
  parameter int          ADDR_W    = 13,
  localparam int         FI_W      = clog2_min1(FRAMES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic              visible,
  input  logic              mirror,
  input  logic              anim_en,
  input  logic [11:0]       data,
  output logic [ADDR_W-1:0] address,
  output logic [FI_W-1:0]   frame_idx,
  vga_if.in                 in,
  vga_if.out                out,
  pos_if.out                host_pos
);

  localparam logic [31:0] FRAME_SZ = 32'(SPR_W * SPR_H);

  vga_t  vga_in, out_q, out_d;
  side_t side_in, side_dly;
  logic  vblnk_rise, inbox;

  logic [9:0]        lat_x_q, lat_x_d, lat_y_q, lat_y_d;
  logic              lat_vis_q, lat_vis_d, lat_mir_q, lat_mir_d;
  logic [10:0]       rel_x_q, rel_x_d, rel_y_q, rel_y_d, col;
  logic              inbox_q;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [11:0]       hx, vy, lx, ly;

  assign vga_in.vcount = in.vcount;
  assign vga_in.vsync  = in.vsync;
  assign vga_in.vblnk  = in.vblnk;
  assign vga_in.hcount = in.hcount;
  assign vga_in.hsync  = in.hsync;
  assign vga_in.hblnk  = in.hblnk;
  assign vga_in.rgb    = in.rgb;

  sprite_anim_ctrl #(
    .FRAMES(FRAMES), .FRAME_DIV(FRAME_DIV), .FI_W(FI_W)
  ) u_anim (
    .clk(clk), .rst(rst), .vblnk(in.vblnk), .anim_en(anim_en),
    .vblnk_rise(vblnk_rise), .frame_idx(frame_idx)
  );

  // Position/visibility snapshot taken once per frame at vblank.
  always_comb begin
    lat_x_d   = lat_x_q;
    lat_y_d   = lat_y_q;
    lat_vis_d = lat_vis_q;
    lat_mir_d = lat_mir_q;
    if (vblnk_rise) begin
      lat_x_d   = pos_x;
      lat_y_d   = pos_y;
      lat_vis_d = visible;
      lat_mir_d = mirror;
    end
  end

  // 12-bit compares so a box hanging past column 1023 never wraps to 0.
  always_comb begin
    hx    = {2'b00, in.hcount};
    vy    = {2'b00, in.vcount};
    lx    = {2'b00, lat_x_q};
    ly    = {2'b00, lat_y_q};
    inbox = lat_vis_q && (hx >= lx) && (hx < lx + 12'(SPR_W))
                      && (vy >= ly) && (vy < ly + 12'(SPR_H));
    rel_x_d = {1'b0, in.hcount} - {1'b0, lat_x_q};
    rel_y_d = {1'b0, in.vcount} - {1'b0, lat_y_q};
  end

  always_comb begin
    col       = lat_mir_q ? 11'(SPR_W - 1) - rel_x_q : rel_x_q;
    address_d = address_q;
    if (inbox_q)
      address_d = ADDR_W'(32'(frame_idx) * FRAME_SZ + 32'(rel_y_q) * 32'(SPR_W) + 32'(col));
  end

  assign side_in.inbox = inbox;
  assign side_in.vga   = vga_in;

  delay #(
    .CLK_DEL(ROM_LAT + 2), .WIDTH($bits(side_t))
  ) u_dly (
    .clk(clk), .rst(rst), .din(side_in), .dout(side_dly)
  );

  always_comb begin
    out_d = side_dly.vga;
    if (side_dly.inbox && data != BG_COLOR) out_d.rgb = data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_x_q   <= '0;
      lat_y_q   <= '0;
      lat_vis_q <= 1'b0;
      lat_mir_q <= 1'b0;
      rel_x_q   <= '0;
      rel_y_q   <= '0;
      inbox_q   <= 1'b0;
      address_q <= '0;
      out_q     <= '0;
    end else begin
      lat_x_q   <= lat_x_d;
      lat_y_q   <= lat_y_d;
      lat_vis_q <= lat_vis_d;
      lat_mir_q <= lat_mir_d;
      rel_x_q   <= rel_x_d;
      rel_y_q   <= rel_y_d;
      inbox_q   <= inbox;
      address_q <= address_d;
      out_q     <= out_d;
    end
  end

  assign address    = address_q;
  assign out.vcount = out_q.vcount;
  assign out.vsync  = out_q.vsync;
  assign out.vblnk  = out_q.vblnk;
  assign out.hcount = out_q.hcount;
  assign out.hsync  = out_q.hsync;
  assign out.hblnk  = out_q.hblnk;
  assign out.rgb    = out_q.rgb;
  assign host_pos.x = lat_x_q;
  assign host_pos.y = lat_y_q;

endmodule

// File: tb/tb_draw_sprite.sv
// Directed bench for draw_sprite: static, mirror, transparency, animation,
// tear-free latch, right-edge clipping and async reset.
module tb_draw_sprite;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  pos_x, pos_y;
  logic        visible, mirror, anim_en;
  logic [11:0] data;
  logic [12:0] address;
  logic [1:0]  frame_idx;
  int          tests = 0;
  int          fails = 0;

  vga_if vin();
  vga_if vout();
  pos_if hp();

  draw_sprite #(
    .SPR_W(32), .SPR_H(48), .FRAMES(4), .FRAME_DIV(2), .ROM_LAT(1),
    .BG_COLOR(12'h0F0), .ADDR_W(13)
  ) dut (
    .clk(clk), .rst(rst), .pos_x(pos_x), .pos_y(pos_y), .visible(visible),
    .mirror(mirror), .anim_en(anim_en), .data(data), .address(address),
    .frame_idx(frame_idx), .in(vin), .out(vout), .host_pos(hp)
  );

  always #5 clk = ~clk;

  // ROM content = low 12 address bits, except word 5 holds the key colour.
  always @(posedge clk) data <= (address == 13'd5) ? 12'h0F0 : address[11:0];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic [9:0] h, input logic [9:0] v, input logic [11:0] rgb, input logic vb);
    vin.hcount = h;
    vin.vcount = v;
    vin.rgb    = rgb;
    vin.vblnk  = vb;
    vin.hblnk  = 1'b0;
    vin.hsync  = 1'b0;
    vin.vsync  = 1'b0;
  endtask

  // One pixel in, idle pixels after; output checked ROM_LAT+3 = 4 cycles on.
  task automatic pix(input string tag, input logic [9:0] h, input logic [9:0] v,
                     input logic [11:0] rgb, input logic [11:0] exp);
    drv(h, v, rgb, 1'b0);
    @(negedge clk);
    drv(10'd0, 10'd0, 12'h000, 1'b0);
    repeat (3) @(negedge clk);
    chk({tag, "_rgb"}, 32'(vout.rgb), 32'(exp));
    chk({tag, "_hcnt"}, 32'(vout.hcount), 32'(h));
  endtask

  task automatic vbl();
    drv(10'd0, 10'd0, 12'h000, 1'b1);
    @(negedge clk);
    drv(10'd0, 10'd0, 12'h000, 1'b0);
    @(negedge clk);
  endtask

  int exp_run[13]  = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0, 1, 1, 2};
  int exp_drain[6] = '{2, 3, 3, 0, 0, 0};

  initial begin
    rst = 1'b0;
    pos_x = 10'd100; pos_y = 10'd50;
    visible = 1'b1; mirror = 1'b0; anim_en = 1'b0;
    drv(10'd5, 10'd7, 12'hFFF, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst_rgb", 32'(vout.rgb), 32'h0);
    chk("rst_hcnt", 32'(vout.hcount), 32'h0);
    chk("rst_addr", 32'(address), 32'h0);
    chk("rst_frame", 32'(frame_idx), 32'h0);
    chk("rst_hostx", 32'(hp.x), 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // Latch still empty before the first vblank.
    pix("pre_vbl", 10'd100, 10'd50, 12'h123, 12'h123);
    vbl();
    chk("host_x", 32'(hp.x), 32'd100);
    chk("host_y", 32'(hp.y), 32'd50);

    // Static draw
    pix("st_topleft", 10'd100, 10'd50, 12'h123, 12'h000);
    pix("st_botright", 10'd131, 10'd97, 12'h123, 12'h5FF);
    chk("st_addr_last", 32'(address), 32'd1535);
    pix("st_right_out", 10'd132, 10'd50, 12'h123, 12'h123);
    pix("st_left_out", 10'd99, 10'd50, 12'h321, 12'h321);
    pix("st_below_out", 10'd100, 10'd98, 12'h444, 12'h444);
    pix("st_inner", 10'd101, 10'd51, 12'h123, 12'h021);

    // Transparency
    pix("tr_key", 10'd105, 10'd50, 12'hABC, 12'hABC);
    pix("tr_next", 10'd106, 10'd50, 12'hABC, 12'h006);

    // Mirror
    mirror = 1'b1;
    vbl();
    pix("mi_left", 10'd100, 10'd50, 12'h123, 12'h01F);
    pix("mi_right", 10'd131, 10'd50, 12'h123, 12'h000);
    pix("mi_right_r1", 10'd131, 10'd51, 12'h123, 12'h020);

    // Tear-free latch
    mirror = 1'b0;
    vbl();
    pos_x = 10'd200;
    pix("tear_old", 10'd100, 10'd50, 12'h123, 12'h000);
    chk("tear_host_old", 32'(hp.x), 32'd100);
    pix("tear_new_out", 10'd200, 10'd50, 12'h456, 12'h456);
    vbl();
    chk("tear_host_new", 32'(hp.x), 32'd200);
    pix("tear_new_in", 10'd200, 10'd50, 12'h456, 12'h000);
    pix("tear_old_out", 10'd100, 10'd50, 12'h123, 12'h123);

    // Animation
    anim_en = 1'b1;
    for (int i = 0; i < 13; i++) begin
      vbl();
      chk($sformatf("anim_run%0d", i), 32'(frame_idx), 32'(exp_run[i]));
    end
    pix("anim_f2_addr", 10'd200, 10'd50, 12'h456, 12'hC00);
    chk("anim_hold", 32'(frame_idx), 32'd2);
    anim_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      vbl();
      chk($sformatf("anim_drain%0d", i), 32'(frame_idx), 32'(exp_drain[i]));
    end

    // Right-edge clipping
    pos_x = 10'd1010;
    vbl();
    pix("edge_first", 10'd1010, 10'd50, 12'h111, 12'h000);
    pix("edge_last", 10'd1023, 10'd50, 12'h111, 12'h00D);
    pix("edge_nowrap", 10'd0, 10'd50, 12'h222, 12'h222);
    pix("edge_before", 10'd1009, 10'd50, 12'h333, 12'h333);

    // Async reset mid-line
    drv(10'd500, 10'd50, 12'hFFF, 1'b0);
    repeat (5) @(negedge clk);
    chk("mid_pre_rgb", 32'(vout.rgb), 32'hFFF);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_rgb", 32'(vout.rgb), 32'h0);
    chk("mid_rst_addr", 32'(address), 32'h0);
    chk("mid_rst_hostx", 32'(hp.x), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    pix("post_rst_nolatch", 10'd1016, 10'd50, 12'h777, 12'h777);
    vbl();
    chk("post_rst_hostx", 32'(hp.x), 32'd1010);
    pix("post_rst_draw", 10'd1016, 10'd50, 12'h777, 12'h006);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
